// File: rtl/fadd_n36_issue_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : fadd_n36_issue_arb_if
//  Purpose  : Bundle of the requester, shared-core and response channels of
//             the FADD-N36 issue arbiter. The slave modport is the arbiter
//             view. The master modport is the view of the requesters and core.
//  Revision : 1.0  initial release
// ============================================================================
interface fadd_n36_issue_arb_if #(
    parameter int FRAC_WIDTH = 36,
    parameter int EXP_WIDTH  = 8
);
    localparam int OPW = 1 + EXP_WIDTH + FRAC_WIDTH;

    // Requester 0 / 1 issue channels
    logic           req0_valid;
    logic           req0_ready;
    logic [OPW-1:0] req0_op_a;
    logic [OPW-1:0] req0_op_b;
    logic           req0_sub;
    logic           req1_valid;
    logic           req1_ready;
    logic [OPW-1:0] req1_op_a;
    logic [OPW-1:0] req1_op_b;
    logic           req1_sub;

    // Shared combinational core
    logic [OPW-1:0] core_op_a;
    logic [OPW-1:0] core_op_b;
    logic           core_sub;
    logic [OPW-1:0] core_res;

    // Response channels
    logic           rsp0_valid;
    logic           rsp0_ready;
    logic [OPW-1:0] rsp0_res;
    logic           rsp1_valid;
    logic           rsp1_ready;
    logic [OPW-1:0] rsp1_res;

    modport slave (
        input  req0_valid, req0_op_a, req0_op_b, req0_sub,
        output req0_ready,
        input  req1_valid, req1_op_a, req1_op_b, req1_sub,
        output req1_ready,
        output core_op_a, core_op_b, core_sub,
        input  core_res,
        output rsp0_valid, rsp0_res,
        input  rsp0_ready,
        output rsp1_valid, rsp1_res,
        input  rsp1_ready
    );

    modport master (
        output req0_valid, req0_op_a, req0_op_b, req0_sub,
        input  req0_ready,
        output req1_valid, req1_op_a, req1_op_b, req1_sub,
        input  req1_ready,
        input  core_op_a, core_op_b, core_sub,
        output core_res,
        input  rsp0_valid, rsp0_res,
        output rsp0_ready,
        input  rsp1_valid, rsp1_res,
        output rsp1_ready
    );
endinterface
`default_nettype wire

// File: rtl/fadd_n36_issue_arb.sv
`default_nettype none
// ============================================================================
//  Module   : fadd_n36_issue_arb
//  Purpose  : Round-robin issue arbiter that shares one combinational FADD-N36
//             core between two requesters. Requests pass through an S1 issue
//             register, which drives the core. The core result is then
//             captured in S2, and responses return in order, tagged by
//             requester.
//  Options  : FADD_ARB_PERF_EN adds the perf_issue0/perf_issue1/perf_stall
//             counters. The counters are 32 bits and saturate.
//  Revision : 1.0  initial release
// ============================================================================
module fadd_n36_issue_arb #(
    parameter int FRAC_WIDTH = 36,
    parameter int EXP_WIDTH  = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    fadd_n36_issue_arb_if.slave       bus
`ifdef FADD_ARB_PERF_EN
    ,
    output logic [31:0]               perf_issue0,
    output logic [31:0]               perf_issue1,
    output logic [31:0]               perf_stall
`endif
);
    localparam int OPW = 1 + EXP_WIDTH + FRAC_WIDTH;

    // Pipeline registers
    logic           s1_valid_q, s1_valid_d;
    logic           s1_tag_q,   s1_tag_d;
    logic [OPW-1:0] s1_op_a_q,  s1_op_a_d;
    logic [OPW-1:0] s1_op_b_q,  s1_op_b_d;
    logic           s1_sub_q,   s1_sub_d;
    logic           s2_valid_q, s2_valid_d;
    logic           s2_tag_q,   s2_tag_d;
    logic [OPW-1:0] s2_res_q,   s2_res_d;
    logic           rr_ptr_q,   rr_ptr_d;

    // Handshake terms
    logic s2_fire;
    logic s2_adv;
    logic s1_acc;
    logic grant0;
    logic grant1;
    logic accept;

    // Flow control and arbitration; ready never depends on core_res
    always_comb begin
        s2_fire = s2_valid_q & (s2_tag_q ? bus.rsp1_ready : bus.rsp0_ready);
        s2_adv  = ~s2_valid_q | s2_fire;
        s1_acc  = ~s1_valid_q | s2_adv;
        grant0  = bus.req0_valid & (~bus.req1_valid | ~rr_ptr_q);
        grant1  = bus.req1_valid & (~bus.req0_valid |  rr_ptr_q);
        // rst_n gating keeps ready low for the whole time reset is asserted
        accept  = (grant0 | grant1) & s1_acc & rst_n;
    end

    assign bus.req0_ready = grant0 & s1_acc & rst_n;
    assign bus.req1_ready = grant1 & s1_acc & rst_n;

    assign bus.core_op_a  = s1_op_a_q;
    assign bus.core_op_b  = s1_op_b_q;
    assign bus.core_sub   = s1_sub_q;

    assign bus.rsp0_valid = s2_valid_q & ~s2_tag_q;
    assign bus.rsp1_valid = s2_valid_q &  s2_tag_q;
    assign bus.rsp0_res   = s2_res_q;
    assign bus.rsp1_res   = s2_res_q;

    // Next-state for S1/S2 and the round-robin pointer
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_tag_d   = s1_tag_q;
        s1_op_a_d  = s1_op_a_q;
        s1_op_b_d  = s1_op_b_q;
        s1_sub_d   = s1_sub_q;
        s2_valid_d = s2_valid_q;
        s2_tag_d   = s2_tag_q;
        s2_res_d   = s2_res_q;
        rr_ptr_d   = rr_ptr_q;

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            s2_tag_d   = s1_tag_q;
            s2_res_d   = bus.core_res;
        end

        if (s1_acc) begin
            s1_valid_d = accept;
            // Operands are only loaded on a real transfer so the core inputs
            // stay quiet while idle
            if (accept) begin
                s1_tag_d  = grant1;
                s1_op_a_d = grant1 ? bus.req1_op_a : bus.req0_op_a;
                s1_op_b_d = grant1 ? bus.req1_op_b : bus.req0_op_b;
                s1_sub_d  = grant1 ? bus.req1_sub  : bus.req0_sub;
            end
        end

        // Hand priority to the requester that just lost
        if (accept) begin
            rr_ptr_d = ~grant1;
        end
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= 1'b0;
            s1_op_a_q  <= '0;
            s1_op_b_q  <= '0;
            s1_sub_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_tag_q   <= 1'b0;
            s2_res_q   <= '0;
            rr_ptr_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            s1_op_a_q  <= s1_op_a_d;
            s1_op_b_q  <= s1_op_b_d;
            s1_sub_q   <= s1_sub_d;
            s2_valid_q <= s2_valid_d;
            s2_tag_q   <= s2_tag_d;
            s2_res_q   <= s2_res_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

`ifdef FADD_ARB_PERF_EN
    localparam logic [31:0] C_PERF_MAX = 32'hFFFF_FFFF;

    logic [31:0] perf_issue0_q, perf_issue0_d;
    logic [31:0] perf_issue1_q, perf_issue1_d;
    logic [31:0] perf_stall_q,  perf_stall_d;

    // Saturating event counters
    always_comb begin
        perf_issue0_d = perf_issue0_q;
        perf_issue1_d = perf_issue1_q;
        perf_stall_d  = perf_stall_q;
        if (accept && !grant1 && (perf_issue0_q != C_PERF_MAX)) begin
            perf_issue0_d = perf_issue0_q + 32'd1;
        end
        if (accept && grant1 && (perf_issue1_q != C_PERF_MAX)) begin
            perf_issue1_d = perf_issue1_q + 32'd1;
        end
        if (s2_valid_q && !s2_fire && (perf_stall_q != C_PERF_MAX)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue0_q <= '0;
            perf_issue1_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issue0_q <= perf_issue0_d;
            perf_issue1_q <= perf_issue1_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issue0 = perf_issue0_q;
    assign perf_issue1 = perf_issue1_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
`default_nettype wire
